// File: rtl/peak_readout_regs.sv
// Double-buffered snapshot registers for the peak finder, served byte-wise to the HPS.
// A read of byte 0 locks the front bank until LAST_ADDR is read, so a snapshot is never torn.
module peak_readout_regs #(
  parameter int PEAKS         = 6,
  parameter int FREQ_WIDTH    = 8,
  parameter int AMPL_WIDTH    = 24,
  parameter int COUNTER_WIDTH = 32,
  parameter int LAST_ADDR     = 33
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_in,
  input  logic [COUNTER_WIDTH-1:0]        counter_in,
  input  logic [PEAKS*FREQ_WIDTH-1:0]     freqs_in,
  input  logic [PEAKS*AMPL_WIDTH-1:0]     amps_in,
  input  logic                            chipselect,
  input  logic                            write,
  input  logic [7:0]                      address,
  input  logic [7:0]                      writedata,
  output logic [7:0]                      readdata
);

  typedef struct packed {
    logic [COUNTER_WIDTH-1:0]             counter;
    logic [PEAKS-1:0][FREQ_WIDTH-1:0]     freq;
    logic [PEAKS-1:0][AMPL_WIDTH-1:0]     ampl;
  } snap_t;

  localparam logic [7:0] LAST_A      = 8'(LAST_ADDR);
  localparam logic [7:0] STATUS_ADDR = 8'd34;

  snap_t       front, back;
  logic        pending, locked, new_data, overflow;

  logic        rd_en, rd_first, rd_last, ovf_clr, swap;
  logic [7:0]  rd_byte;
  logic [7:0]  status;
  logic [4:0]  amp_rel;
  logic [AMPL_WIDTH-1:0] amp_word;
  logic        unused_wdata;

  assign rd_en    = chipselect && !write;
  assign rd_first = rd_en && (address == 8'd0);
  assign rd_last  = rd_en && (address == LAST_A);
  assign ovf_clr  = chipselect && write && (address == STATUS_ADDR) && writedata[1];
  // Opening a read sequence wins over a waiting swap, so byte 0 always comes from the bank it locks.
  assign swap     = pending && !locked && !rd_first;

  assign status       = {4'b0000, pending, locked, overflow, new_data};
  assign amp_rel      = 5'(address - 8'd10);
  assign unused_wdata = ^{writedata[7:2], writedata[0]};

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    rd_byte  = 8'h00;
    amp_word = '0;
    for (int k = 0; k < PEAKS; k++) begin
      if (amp_rel[4:2] == 3'(k)) amp_word = front.ampl[k];
    end
    case (address) inside
      [8'd0:8'd3]: begin
        case (address[1:0])
          2'd0:    rd_byte = front.counter[31:24];
          2'd1:    rd_byte = front.counter[23:16];
          2'd2:    rd_byte = front.counter[15:8];
          default: rd_byte = front.counter[7:0];
        endcase
      end
      [8'd4:8'd9]: begin
        for (int k = 0; k < PEAKS; k++) begin
          if (address == 8'(4 + k)) rd_byte = front.freq[k];
        end
      end
      [8'd10:8'd33]: begin
        case (amp_rel[1:0])
          2'd0:    rd_byte = amp_word[23:16];
          2'd1:    rd_byte = amp_word[15:8];
          2'd2:    rd_byte = amp_word[7:0];
          default: rd_byte = 8'h00;
        endcase
      end
      STATUS_ADDR: rd_byte = status;
      [8'd248:8'd255]: begin
        case (address[2:0])
          3'd0:    rd_byte = 8'd42;
          3'd1:    rd_byte = 8'd53;
          3'd2:    rd_byte = 8'd84;
          3'd3:    rd_byte = 8'd71;
          3'd4:    rd_byte = 8'd7;
          3'd5:    rd_byte = 8'd25;
          3'd6:    rd_byte = 8'd48;
          default: rd_byte = 8'd96;
        endcase
      end
      default: rd_byte = 8'h00;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every branch sees start-of-cycle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the banks are cleared too, so a read straight after reset never exposes a stale snapshot.
      front    <= '0;
      back     <= '0;
      pending  <= 1'b0;
      locked   <= 1'b0;
      new_data <= 1'b0;
      overflow <= 1'b0;
      readdata <= 8'h00;
    end else begin
      if (rd_en) readdata <= rd_byte;

      if (swap) begin
        front    <= back;
        new_data <= 1'b1;
      end else if (rd_first) begin
        new_data <= 1'b0;
      end

      if (valid_in) begin
        back    <= {counter_in, freqs_in, amps_in};
        pending <= 1'b1;
      end else if (swap) begin
        pending <= 1'b0;
      end

      if (valid_in && pending && !swap) overflow <= 1'b1;
      else if (ovf_clr)                 overflow <= 1'b0;

      if (rd_first)     locked <= 1'b1;
      else if (rd_last) locked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_peak_readout_regs.sv
// Directed bench for peak_readout_regs: the driver queues the expected byte for each read,
// and a monitor compares it against readdata one cycle after the read is accepted.
module tb_peak_readout_regs;

  typedef struct packed {
    logic [31:0]      cnt;
    logic [5:0][7:0]  f;
    logic [5:0][23:0] am;
  } snap_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic [31:0]  counter_in;
  logic [47:0]  freqs_in;
  logic [143:0] amps_in;
  logic         chipselect;
  logic         write;
  logic [7:0]   address;
  logic [7:0]   writedata;
  logic [7:0]   readdata;

  logic [7:0]   exp_q[$];
  string        name_q[$];
  logic         chk = 1'b0;
  int           checks = 0;
  int           errors = 0;

  snap_t sa, sb, sc, sd, se, sf, sg, sh, si, sj;

  peak_readout_regs dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .counter_in (counter_in),
    .freqs_in   (freqs_in),
    .amps_in    (amps_in),
    .chipselect (chipselect),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: readdata=%02h expected=%02h", name, act, exp);
    end
  endtask

  // Byte image of a snapshot as the driver should see it through the front bank.
  function automatic logic [7:0] img_byte(input snap_t s, input int a);
    logic [7:0] r;
    int k, o;
    r = 8'h00;
    if (a < 4) begin
      r = s.cnt[8*(3-a) +: 8];
    end else if (a < 10) begin
      r = s.f[a-4];
    end else if (a < 34) begin
      k = (a - 10) / 4;
      o = (a - 10) % 4;
      case (o)
        0:       r = s.am[k][23:16];
        1:       r = s.am[k][15:8];
        2:       r = s.am[k][7:0];
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

  task automatic issue_rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    chipselect = 1'b1;
    write      = 1'b0;
    address    = a;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  task automatic issue_wr(input logic [7:0] a, input logic [7:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
  endtask

  task automatic issue_snap(input snap_t s);
    valid_in   = 1'b1;
    counter_in = s.cnt;
    freqs_in   = s.f;
    amps_in    = s.am;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
    valid_in   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    issue_rd(a, exp, name);
    tick();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    issue_wr(a, d);
    tick();
  endtask

  // Monitor: a read accepted at a rising edge must show its byte by the following falling edge.
  always @(posedge clk) chk <= chipselect && !write;

  always @(negedge clk) begin
    if (chk) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor_underflow: readdata=%02h with no queued expectation", readdata);
      end else begin
        check(name_q.pop_front(), readdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    sa = '0; sa.cnt = 32'h12345678; sa.f[2] = 8'hA5; sa.am[5] = 24'hABCDEF;
    sb = '0; sb.cnt = 32'h00000002; sb.f[0] = 8'h11; sb.am[0] = 24'h223344;
    sc = '0; sc.cnt = 32'hCAFEF00D;
    sd = '0; sd.cnt = 32'hDEADBEEF;
    se = '0; se.cnt = 32'hE0E0E0E0;
    sf = '0; sf.cnt = 32'hF1F2F3F4;
    sg = '0; sg.cnt = 32'h01020304;
    sh = '0; sh.cnt = 32'h0A0B0C0D;
    si = '0; si.cnt = 32'h55555555;
    sj = '0; sj.cnt = 32'h66666666;

    reset = 1'b1; valid_in = 1'b0; counter_in = '0; freqs_in = '0; amps_in = '0;
    chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // Reset state and constant bytes.
    rd(8'd34,  8'h00, "rst_status");
    rd(8'd0,   8'h00, "rst_byte0");
    rd(8'd248, 8'd42, "const_248");
    rd(8'd255, 8'd96, "const_255");
    rd(8'd100, 8'h00, "gap_100");
    rd(8'd33,  8'h00, "rst_byte33");

    // First snapshot: captured, then swapped to the front one cycle later.
    issue_snap(sa); tick();
    tick();
    rd(8'd34, 8'h01, "a_status_new");
    rd(8'd0,  8'h12, "a_byte0");
    rd(8'd34, 8'h04, "a_status_locked");
    rd(8'd1,  8'h34, "a_byte1");
    rd(8'd2,  8'h56, "a_byte2");
    rd(8'd3,  8'h78, "a_byte3");
    rd(8'd4,  8'h00, "a_byte4");
    rd(8'd6,  8'hA5, "a_byte6");
    rd(8'd30, 8'hAB, "a_byte30");
    rd(8'd31, 8'hCD, "a_byte31");
    rd(8'd32, 8'hEF, "a_byte32");
    rd(8'd33, 8'h00, "a_byte33");
    rd(8'd34, 8'h00, "a_status_idle");

    // Lock holds the front bank while a new snapshot waits.
    rd(8'd0, 8'h12, "lock_byte0");
    issue_snap(sb); tick();
    rd(8'd34, 8'h0C, "lock_status_pending");
    for (int a = 1; a <= 33; a++) rd(8'(a), img_byte(sa, a), $sformatf("lock_hold_%0d", a));
    tick();
    rd(8'd0,  8'h00, "b_byte0");
    rd(8'd1,  8'h00, "b_byte1");
    rd(8'd2,  8'h00, "b_byte2");
    rd(8'd3,  8'h02, "b_byte3");
    rd(8'd4,  8'h11, "b_byte4");
    rd(8'd10, 8'h22, "b_byte10");
    rd(8'd11, 8'h33, "b_byte11");
    rd(8'd12, 8'h44, "b_byte12");
    rd(8'd13, 8'h00, "b_byte13");
    rd(8'd34, 8'h04, "b_status_locked");

    // Overflow: two captures while locked; the second one wins.
    rd(8'd0, 8'h00, "relock_byte0");
    issue_snap(sc); tick();
    tick();
    tick();
    issue_snap(sd); tick();
    rd(8'd34, 8'h0E, "ovf_status");
    rd(8'd33, 8'h00, "ovf_unlock");
    tick();
    rd(8'd34, 8'h03, "ovf_status_swapped");
    rd(8'd0,  8'hDE, "d_byte0");
    rd(8'd3,  8'hEF, "d_byte3");
    rd(8'd33, 8'h00, "d_byte33");
    wr(8'd35, 8'h02);
    rd(8'd34, 8'h02, "wr_other_addr");
    wr(8'd34, 8'h01);
    rd(8'd34, 8'h02, "wr_bit1_clear");
    wr(8'd34, 8'h02);
    rd(8'd34, 8'h00, "ovf_cleared");

    // Capture on the same cycle as a read of byte 0 with a snapshot pending: no swap.
    issue_snap(se); tick();
    issue_snap(sf); issue_rd(8'd0, 8'hDE, "simul_rd0_no_swap"); tick();
    rd(8'd34, 8'h0E, "simul_status");
    rd(8'd33, 8'h00, "simul_unlock");
    tick();
    rd(8'd34, 8'h03, "simul_swapped");
    wr(8'd34, 8'h02);
    rd(8'd34, 8'h01, "simul_ovf_cleared");
    rd(8'd0,  8'hF1, "f_byte0");
    rd(8'd33, 8'h00, "f_byte33");

    // Capture on the same cycle as a swap: pending stays set, no overflow.
    issue_snap(sg); tick();
    issue_snap(sh); tick();
    rd(8'd0,  8'h01, "g_byte0");
    rd(8'd34, 8'h0C, "swapcap_status");
    rd(8'd33, 8'h00, "g_unlock");
    tick();
    rd(8'd0,  8'h0A, "h_byte0");

    // Overflow set and clear in one cycle: set wins. Then reset mid-sequence.
    issue_snap(si); tick();
    issue_snap(sj); issue_wr(8'd34, 8'h02); tick();
    rd(8'd34, 8'h0E, "set_wins_status");
    reset = 1'b1;
    issue_rd(8'd248, 8'h00, "reset_readdata");
    tick();
    reset = 1'b0;
    rd(8'd34,  8'h00, "post_rst_status");
    rd(8'd0,   8'h00, "post_rst_byte0");
    rd(8'd30,  8'h00, "post_rst_byte30");
    rd(8'd33,  8'h00, "post_rst_unlock");
    tick();
    rd(8'd34,  8'h00, "post_rst_no_swap");
    rd(8'd249, 8'd53, "const_249");
    rd(8'd200, 8'h00, "gap_200");

    tick();
    tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expected bytes never observed", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
